fft16_input_loader: RTL and testbench

Upstream input stage of the 16-point radix-2 FFT core. Accepts a time-ordered stream of complex Q8 samples at two samples per beat, buffers each 16-sample frame in a ping-pong (two-bank) register file, and re-emits the frame in bit-reversed order. Each output beat is the pair consumed by one first-stage butterfly. One bank fills while the other drains, so it sustains one beat per cycle in both directions.

---
 rtl/fft16_input_loader.sv | 124 ++++++++++++
 tb/tb_fft16_input_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_input_loader.sv
// Purpose: 16-point FFT input stage; buffers 2-sample beats into ping-pong banks, re-emits each frame bit-reversed.
// Latency: first output beat valid the cycle after the 8th input beat of a frame is accepted.
// Backpressure: valid/ready both sides; o_ready drops only when the write bank still holds an undrained frame.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-low reset
//   i_valid/o_ready, in0_*, in1_*     input beat: time samples 2k (in0) and 2k+1 (in1)
//   o_valid/i_ready, out0_*, out1_*   output beat j: x[bitrev4(2j)] (out0), x[bitrev4(2j+1)] (out1)
//   o_frame_start, o_frame_last       qualify output beats j=0 and j=7
module fft16_input_loader #(
    parameter int N      = 16,
    parameter int POINTS = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] in0_re,
    input  logic [N-1:0] in0_im,
    input  logic [N-1:0] in1_re,
    input  logic [N-1:0] in1_im,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] out0_re,
    output logic [N-1:0] out0_im,
    output logic [N-1:0] out1_re,
    output logic [N-1:0] out1_im,
    output logic         o_frame_start,
    output logic         o_frame_last
);

    typedef struct packed {
        logic [N-1:0] re;
        logic [N-1:0] im;
    } cplx_t;

    // Sample storage: [bank][time index]
    cplx_t mem_q [2][POINTS];
    cplx_t mem_d [2][POINTS];

    logic       wbank_q, wbank_d;
    logic       rbank_q, rbank_d;
    logic [2:0] wcnt_q,  wcnt_d;
    logic [2:0] rcnt_q,  rcnt_d;
    logic [1:0] full_q,  full_d;

    logic       wr_fire;
    logic       rd_fire;
    logic [2:0] rsel;
    cplx_t      rd0;
    cplx_t      rd1;

    // Both flags come straight from registers, so neither handshake
    // side depends combinationally on the other.
    assign o_ready = !full_q[wbank_q];
    assign o_valid = full_q[rbank_q];
    assign wr_fire = i_valid && o_ready;
    assign rd_fire = o_valid && i_ready;

    // Drain beat j reads entries bitrev3(j) and bitrev3(j)+8; with the
    // MSB of the 4-bit index forced, this is exactly bitrev4(2j) / bitrev4(2j+1).
    assign rsel = {rcnt_q[0], rcnt_q[1], rcnt_q[2]};
    assign rd0  = mem_q[rbank_q][{1'b0, rsel}];
    assign rd1  = mem_q[rbank_q][{1'b1, rsel}];

    assign out0_re       = rd0.re;
    assign out0_im       = rd0.im;
    assign out1_re       = rd1.re;
    assign out1_im       = rd1.im;
    assign o_frame_start = o_valid && (rcnt_q == 3'd0);
    assign o_frame_last  = o_valid && (rcnt_q == 3'd7);

    always_comb begin
        mem_d   = mem_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        full_d  = full_q;

        if (wr_fire) begin
            mem_d[wbank_q][{wcnt_q, 1'b0}] = {in0_re, in0_im};
            mem_d[wbank_q][{wcnt_q, 1'b1}] = {in1_re, in1_im};
            wcnt_d = wcnt_q + 3'd1;
            if (wcnt_q == 3'd7) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = !wbank_q;
            end
        end

        // Fill and drain always address different banks, so a fill-complete
        // set and a drain-complete clear in the same cycle never collide.
        if (rd_fire) begin
            rcnt_d = rcnt_q + 3'd1;
            if (rcnt_q == 3'd7) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = !rbank_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wcnt_q  <= 3'd0;
            rcnt_q  <= 3'd0;
            full_q  <= 2'b00;
        end else begin
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            full_q  <= full_d;
        end
    end

    // Storage is deliberately not reset; stale contents are unreachable
    // because full_q gates every read.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fft16_input_loader.sv
// Purpose: self-checking bench for fft16_input_loader against a frame-queue reference model.
// Latency: model predicts o_valid the cycle after a frame's 8th accepted beat.
// Backpressure: model predicts o_ready low exactly while two complete frames are held.
module tb_fft16_input_loader;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] in0_re, in0_im, in1_re, in1_im;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] out0_re, out0_im, out1_re, out1_im;
    logic        o_frame_start;
    logic        o_frame_last;

    fft16_input_loader #(.N(16), .POINTS(16)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .in0_re        (in0_re),
        .in0_im        (in0_im),
        .in1_re        (in1_re),
        .in1_im        (in1_im),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .out0_re       (out0_re),
        .out0_im       (out0_im),
        .out1_re       (out1_re),
        .out1_im       (out1_im),
        .o_frame_start (o_frame_start),
        .o_frame_last  (o_frame_last)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: complete frames waiting/being drained, in arrival order.
    // Each frame packs 16 samples of {re,im}, sample n at bits [n*32 +: 32].
    typedef logic [511:0] frame_t;
    frame_t frames_q[$];
    frame_t fill_f;
    int     fill_n  = 0;
    int     drain_j = 0;

    // Observed DUT outputs and model expectations for the current cycle.
    logic        ob_vld, ob_rdy, ob_fs, ob_fl;
    logic [31:0] ob0, ob1;
    logic        e_vld, e_rdy, e_fs, e_fl;
    logic [31:0] e0, e1;

    function automatic int bitrev4(input int x);
        return ((x & 1) << 3) | ((x & 2) << 1) | ((x & 4) >> 1) | ((x & 8) >> 3);
    endfunction

    // One clock cycle: sample outputs at the falling edge, predict them from
    // the model, drive the next inputs, then advance the model by whatever
    // handshakes will happen on the coming rising edge.
    task automatic step(input bit v, input bit rdy, input logic [31:0] s0,
                        input logic [31:0] s1, output bit acc, output bit took);
        frame_t f;
        @(negedge i_clk);
        ob_vld = o_valid;
        ob_rdy = o_ready;
        ob_fs  = o_frame_start;
        ob_fl  = o_frame_last;
        ob0    = {out0_re, out0_im};
        ob1    = {out1_re, out1_im};

        e_vld = (frames_q.size() != 0);
        e_rdy = (frames_q.size() < 2);
        e_fs  = e_vld && (drain_j == 0);
        e_fl  = e_vld && (drain_j == 7);
        e0    = '0;
        e1    = '0;
        if (e_vld) begin
            f  = frames_q[0];
            e0 = f[bitrev4(2 * drain_j) * 32 +: 32];
            e1 = f[bitrev4(2 * drain_j + 1) * 32 +: 32];
        end

        i_valid = v;
        i_ready = rdy;
        {in0_re, in0_im} = s0;
        {in1_re, in1_im} = s1;
        acc  = v && ob_rdy;
        took = rdy && ob_vld;

        if (rdy && e_vld) begin
            drain_j++;
            if (drain_j == 8) begin
                f       = frames_q.pop_front();
                drain_j = 0;
            end
        end
        if (acc) begin
            fill_f[fill_n * 32 +: 32]       = s0;
            fill_f[(fill_n + 1) * 32 +: 32] = s1;
            fill_n += 2;
            if (fill_n == 16) begin
                frames_q.push_back(fill_f);
                fill_n = 0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        {in0_re, in0_im, in1_re, in1_im} = '0;
        @(negedge i_clk);
        n_cmp += 4;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        if (o_frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fstart: got %b want 0", o_frame_start); end
        if (o_frame_last !== 1'b0) begin n_fail++; $display("FAIL reset_flast: got %b want 0", o_frame_last); end
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        i_rst = 1'b1;
        frames_q.delete();
        fill_n  = 0;
        drain_j = 0;
    endtask

    task automatic test_ramp();
        int ramp0[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int n = 0;
        int k = 0;
        bit acc, took;
        for (int c = 0; c < 24; c++) begin
            step(n < 16, 1'b1, {16'(n * 256), 16'h0}, {16'((n + 1) * 256), 16'h0}, acc, took);
            n_cmp += 3;
            if (ob_vld !== e_vld) begin n_fail++; $display("FAIL ramp_valid cyc %0d: got %b want %b", c, ob_vld, e_vld); end
            if (ob_rdy !== e_rdy) begin n_fail++; $display("FAIL ramp_ready cyc %0d: got %b want %b", c, ob_rdy, e_rdy); end
            if ({ob_fs, ob_fl} !== {e_fs, e_fl}) begin n_fail++; $display("FAIL ramp_flags cyc %0d: got %b%b want %b%b", c, ob_fs, ob_fl, e_fs, e_fl); end
            if (e_vld) begin
                n_cmp++;
                if (ob0 !== e0 || ob1 !== e1) begin n_fail++; $display("FAIL ramp_data cyc %0d: got %h/%h want %h/%h", c, ob0, ob1, e0, e1); end
            end
            if (took && k < 8) begin
                n_cmp++;
                if (ob0[31:16] !== 16'(ramp0[k] * 256) || ob1[31:16] !== 16'((ramp0[k] + 8) * 256)) begin
                    n_fail++;
                    $display("FAIL ramp_order beat %0d: got %h/%h want %0d/%0d", k, ob0[31:16], ob1[31:16], ramp0[k], ramp0[k] + 8);
                end
                k++;
            end
            if (acc) n += 2;
        end
        n_cmp++;
        if (k != 8) begin n_fail++; $display("FAIL ramp_beats: got %0d want 8", k); end
    endtask

    // Four frames streamed with no gaps; frame boundaries on both sides land
    // on the same edge, exercising simultaneous fill- and drain-complete.
    task automatic test_back_to_back();
        int n = 0;
        int takes = 0;
        int first_c = -1;
        int last_c = -1;
        bit acc, took;
        for (int c = 0; c < 48; c++) begin
            step(n < 64, 1'b1, {16'($urandom), 16'(n / 16)}, {16'($urandom), 16'(n / 16)}, acc, took);
            n_cmp += 3;
            if (ob_vld !== e_vld) begin n_fail++; $display("FAIL b2b_valid cyc %0d: got %b want %b", c, ob_vld, e_vld); end
            if (ob_rdy !== e_rdy) begin n_fail++; $display("FAIL b2b_ready cyc %0d: got %b want %b", c, ob_rdy, e_rdy); end
            if ({ob_fs, ob_fl} !== {e_fs, e_fl}) begin n_fail++; $display("FAIL b2b_flags cyc %0d: got %b%b want %b%b", c, ob_fs, ob_fl, e_fs, e_fl); end
            if (e_vld) begin
                n_cmp++;
                if (ob0 !== e0 || ob1 !== e1) begin n_fail++; $display("FAIL b2b_data cyc %0d: got %h/%h want %h/%h", c, ob0, ob1, e0, e1); end
            end
            if (took) begin
                takes++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (acc) n += 2;
        end
        n_cmp += 2;
        if (takes != 32) begin n_fail++; $display("FAIL b2b_count: got %0d want 32", takes); end
        if (last_c - first_c != 31) begin n_fail++; $display("FAIL b2b_gapless: got span %0d want 31", last_c - first_c); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d[48];
        logic [63:0] hold;
        bit have_hold = 0;
        int b = 0;
        bit acc, took;
        for (int i = 0; i < 48; i++) d[i] = $urandom;
        for (int c = 0; c < 120; c++) begin
            bit rdy = (c >= 40);
            step(b < 48, rdy, (b < 48) ? d[b] : 32'h0, (b < 48) ? d[b + 1] : 32'h0, acc, took);
            n_cmp += 3;
            if (ob_vld !== e_vld) begin n_fail++; $display("FAIL bp_valid cyc %0d: got %b want %b", c, ob_vld, e_vld); end
            if (ob_rdy !== e_rdy) begin n_fail++; $display("FAIL bp_ready cyc %0d: got %b want %b", c, ob_rdy, e_rdy); end
            if ({ob_fs, ob_fl} !== {e_fs, e_fl}) begin n_fail++; $display("FAIL bp_flags cyc %0d: got %b%b want %b%b", c, ob_fs, ob_fl, e_fs, e_fl); end
            if (e_vld) begin
                n_cmp++;
                if (ob0 !== e0 || ob1 !== e1) begin n_fail++; $display("FAIL bp_data cyc %0d: got %h/%h want %h/%h", c, ob0, ob1, e0, e1); end
            end
            if (c < 40 && ob_vld) begin
                if (!have_hold) begin
                    hold      = {ob0, ob1};
                    have_hold = 1;
                end else begin
                    n_cmp++;
                    if ({ob0, ob1} !== hold) begin n_fail++; $display("FAIL bp_stable cyc %0d: got %h want %h", c, {ob0, ob1}, hold); end
                end
            end
            if (c == 39) begin
                n_cmp += 2;
                if (b != 32) begin n_fail++; $display("FAIL bp_accepted: got %0d samples want 32", b); end
                if (ob_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: got %b want 0", ob_rdy); end
            end
            if (acc) b += 2;
        end
    endtask

    task automatic test_sparse();
        int n = 0;
        bit acc, took;
        for (int c = 0; c < 70; c++) begin
            step((c % 3 == 0) && n < 32, 1'b1, {16'(-(n * 256)), 16'($urandom)},
                 {16'(-((n + 1) * 256)), 16'($urandom)}, acc, took);
            n_cmp += 3;
            if (ob_vld !== e_vld) begin n_fail++; $display("FAIL sparse_valid cyc %0d: got %b want %b", c, ob_vld, e_vld); end
            if (ob_rdy !== e_rdy) begin n_fail++; $display("FAIL sparse_ready cyc %0d: got %b want %b", c, ob_rdy, e_rdy); end
            if ({ob_fs, ob_fl} !== {e_fs, e_fl}) begin n_fail++; $display("FAIL sparse_flags cyc %0d: got %b%b want %b%b", c, ob_fs, ob_fl, e_fs, e_fl); end
            if (e_vld) begin
                n_cmp++;
                if (ob0 !== e0 || ob1 !== e1) begin n_fail++; $display("FAIL sparse_data cyc %0d: got %h/%h want %h/%h", c, ob0, ob1, e0, e1); end
            end
            if (acc) n += 2;
        end
    endtask

    // Frame A held, then drained while frame B is 5 beats into its fill;
    // reset lands there, and a fresh frame must start cleanly afterwards.
    task automatic test_reset_mid();
        int n = 0;
        bit acc, took;
        for (int c = 0; c < 13; c++) begin
            step(1'b1, c >= 8, $urandom, $urandom, acc, took);
            n_cmp++;
            if (ob_vld !== e_vld) begin n_fail++; $display("FAIL rstmid_pre_valid cyc %0d: got %b want %b", c, ob_vld, e_vld); end
        end
        test_reset();
        for (int c = 0; c < 24; c++) begin
            step(n < 16, 1'b1, $urandom, $urandom, acc, took);
            n_cmp += 3;
            if (ob_vld !== e_vld) begin n_fail++; $display("FAIL rstmid_valid cyc %0d: got %b want %b", c, ob_vld, e_vld); end
            if (ob_rdy !== e_rdy) begin n_fail++; $display("FAIL rstmid_ready cyc %0d: got %b want %b", c, ob_rdy, e_rdy); end
            if ({ob_fs, ob_fl} !== {e_fs, e_fl}) begin n_fail++; $display("FAIL rstmid_flags cyc %0d: got %b%b want %b%b", c, ob_fs, ob_fl, e_fs, e_fl); end
            if (e_vld) begin
                n_cmp++;
                if (ob0 !== e0 || ob1 !== e1) begin n_fail++; $display("FAIL rstmid_data cyc %0d: got %h/%h want %h/%h", c, ob0, ob1, e0, e1); end
            end
            if (acc) n += 2;
        end
    endtask

    task automatic test_random_stress();
        int n = 0;
        bit acc, took;
        for (int c = 0; c < 300; c++) begin
            step((n < 96) && ($urandom_range(0, 3) != 0), $urandom_range(0, 3) != 0,
                 $urandom, $urandom, acc, took);
            n_cmp += 3;
            if (ob_vld !== e_vld) begin n_fail++; $display("FAIL stress_valid cyc %0d: got %b want %b", c, ob_vld, e_vld); end
            if (ob_rdy !== e_rdy) begin n_fail++; $display("FAIL stress_ready cyc %0d: got %b want %b", c, ob_rdy, e_rdy); end
            if ({ob_fs, ob_fl} !== {e_fs, e_fl}) begin n_fail++; $display("FAIL stress_flags cyc %0d: got %b%b want %b%b", c, ob_fs, ob_fl, e_fs, e_fl); end
            if (e_vld) begin
                n_cmp++;
                if (ob0 !== e0 || ob1 !== e1) begin n_fail++; $display("FAIL stress_data cyc %0d: got %h/%h want %h/%h", c, ob0, ob1, e0, e1); end
            end
            if (acc) n += 2;
        end
        n_cmp++;
        if (n != 96) begin n_fail++; $display("FAIL stress_accepted: got %0d samples want 96", n); end
    endtask

    initial begin
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        {in0_re, in0_im, in1_re, in1_im} = '0;
        test_reset();
        test_ramp();
        test_back_to_back();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        test_random_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
